// File: rtl/if_id_pkg.sv
// Shared IF/ID types: NOP encoding, fetch packet layout and buffer state encoding.
package if_id_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instn;
    logic        jump;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline payload register with load enable; shared by the IF/ID, ID/EX and EX/MEM buffers.
module pipe_skid_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/if_id_stage_buf.sv
// IF/ID skid buffer (1 or 2 entries) with valid/ready handshake and synchronous flush.
// Optional stall/flush counters are enabled by defining IF_ID_STAGE_BUF_PERF_EN.
module if_id_stage_buf
  import if_id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int JADDR_W = 26,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [PC_W-1:0]    in_pc_plus4,
  input  logic [DATA_W-1:0]  in_instn,
  input  logic               in_jump,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_plus4,
  output logic [DATA_W-1:0]  out_instn,
  output logic               out_jump,
  output logic [JADDR_W-1:0] out_jump_addr,
  output logic [1:0]         occupancy
`ifdef IF_ID_STAGE_BUF_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam int PKT_W = 2 * PC_W + DATA_W + 1;

  state_t           state_q, state_d;
  logic             push, pop;
  logic             head_load, skid_load;
  logic [PKT_W-1:0] in_pkt, head_d, head_q, skid_q;
  logic [DATA_W-1:0] head_instn;

  assign in_pkt    = {in_pc, in_pc_plus4, in_instn, in_jump};
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    head_load = 1'b0;
    skid_load = 1'b0;
    head_d    = in_pkt;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d   = ST_ONE;
          head_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_load = 1'b1;
        end else if (push) begin
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Skid entry advances to head on the same edge the head is consumed.
        if (pop) begin
          state_d   = ST_ONE;
          head_load = 1'b1;
          head_d    = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d   = ST_EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_skid_slot #(.W(PKT_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (head_load),
    .d     (head_d),
    .q     (head_q)
  );

  generate
    if (DEPTH == 1) begin : g_depth1
      // Single entry: accept only when the head is empty or leaving this cycle.
      assign in_ready = ~out_valid | out_ready;
      assign skid_q   = '0;
    end else begin : g_depth2
      logic in_ready_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != ST_FULL);
        end
      end

      assign in_ready = in_ready_q;

      pipe_skid_slot #(.W(PKT_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_pkt),
        .q     (skid_q)
      );
    end
  endgenerate

  assign out_pc        = head_q[PKT_W-1 -: PC_W];
  assign out_pc_plus4  = head_q[PKT_W-PC_W-1 -: PC_W];
  assign head_instn    = head_q[DATA_W:1];
  assign out_instn     = out_valid ? head_instn : DATA_W'(NOP_INSTR);
  assign out_jump      = out_valid & head_q[0];
  assign out_jump_addr = out_instn[JADDR_W-1:0];
  assign occupancy     = state_q;

`ifdef IF_ID_STAGE_BUF_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (in_valid && !in_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && (state_q != ST_EMPTY)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
